// File: rtl/cpu_run_monitor_if.sv
// Fault-log drain port of cpu_run_monitor: head entry plus valid/ready handshake.
interface cpu_run_monitor_if #(
   parameter int unsigned CORE_W = 1,
   parameter int unsigned CNT_W  = 32
);
   logic              log_valid;
   logic              log_ready;
   logic [CORE_W-1:0] log_core;
   logic [CNT_W-1:0]  log_cycle;

   modport master (output log_valid, log_core, log_cycle, input log_ready);
   modport slave  (input log_valid, log_core, log_cycle, output log_ready);
endinterface

// File: rtl/cpu_run_monitor.sv
// Run supervisor: sequences a run, counts cycles, classifies each core as
// halted / faulted / timed out, and logs faults into a drainable FIFO.
module cpu_run_monitor #(
   parameter int unsigned NUM_CPUS  = 2,
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned TIMEOUT   = 1000,
   parameter int unsigned LOG_DEPTH = 4,
   parameter int unsigned CORE_W    = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [NUM_CPUS-1:0]     halt,
   input  logic [NUM_CPUS-1:0]     exception,
   output logic [CNT_W-1:0]        cycle_count,
   output logic [3*NUM_CPUS-1:0]   core_state,
   output logic                    done,
   output logic                    pass,
   cpu_run_monitor_if.master       log_if
);

   localparam int unsigned PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
   localparam int unsigned LOG_W = CORE_W + CNT_W;

   localparam logic [2:0] CS_IDLE    = 3'd0;
   localparam logic [2:0] CS_RUNNING = 3'd1;
   localparam logic [2:0] CS_HALTED  = 3'd2;
   localparam logic [2:0] CS_FAULT   = 3'd3;
   localparam logic [2:0] CS_TIMEOUT = 3'd4;

   typedef enum logic [1:0] {
      TOP_IDLE = 2'd0,
      TOP_RUN  = 2'd1,
      TOP_DONE = 2'd2
   } top_e;

   top_e                            top_q, top_d;
   logic [CNT_W-1:0]                cycle_q, cycle_d;
   logic [NUM_CPUS-1:0][2:0]        core_q, core_d;
   logic [NUM_CPUS-1:0][CNT_W-1:0]  fault_cycle_q, fault_cycle_d;
   logic [NUM_CPUS-1:0]             pending_q, pending_d;
   logic                            done_q, done_d;
   logic                            pass_q, pass_d;
   logic [LOG_DEPTH-1:0][LOG_W-1:0] fifo_q, fifo_d;
   logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]                  count_q, count_d;

   logic              start_run;
   logic              any_running;
   logic              all_halted;
   logic              fifo_full;
   logic              pop;
   logic              push;
   logic              sel_vld;
   logic [CORE_W-1:0] sel;

   assign start_run = start && (top_q != TOP_RUN);
   assign fifo_full = (count_q == (PTR_W+1)'(LOG_DEPTH));
   assign pop       = log_if.log_valid && log_if.log_ready;

   // Core summary flags and lowest-index pending fault
   always_comb begin
      any_running = 1'b0;
      all_halted  = 1'b1;
      sel_vld     = 1'b0;
      sel         = '0;
      for (int unsigned i = 0; i < NUM_CPUS; i++) begin
         if (core_q[i] == CS_RUNNING) any_running = 1'b1;
         if (core_q[i] != CS_HALTED)  all_halted  = 1'b0;
         if (pending_q[i] && !sel_vld) begin
            sel_vld = 1'b1;
            sel     = CORE_W'(i);
         end
      end
   end

   // Top FSM state register
   always_ff @(posedge clk) begin
      if (rst) top_q <= TOP_IDLE;
      else     top_q <= top_d;
   end

   // Top FSM next state
   always_comb begin
      top_d = top_q;
      unique case (top_q)
         TOP_IDLE, TOP_DONE: if (start) top_d = TOP_RUN;
         TOP_RUN:            if (!any_running && (pending_q == '0)) top_d = TOP_DONE;
         default:            top_d = TOP_IDLE;
      endcase
   end

   // Outputs and datapath next values
   always_comb begin
      cycle_d       = cycle_q;
      core_d        = core_q;
      fault_cycle_d = fault_cycle_q;
      pending_d     = pending_q;
      fifo_d        = fifo_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      push          = 1'b0;
      done_d        = (top_d == TOP_DONE);
      pass_d        = (top_d == TOP_DONE) && all_halted;

      if (start_run) begin
         cycle_d   = '0;
         pending_d = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         for (int unsigned i = 0; i < NUM_CPUS; i++) core_d[i] = CS_RUNNING;
      end else begin
         // Counter freezes on the edge that leaves RUN
         if ((top_q == TOP_RUN) && (top_d == TOP_RUN) && (cycle_q != '1))
            cycle_d = cycle_q + CNT_W'(1);

         if (top_q == TOP_RUN) begin
            for (int unsigned i = 0; i < NUM_CPUS; i++) begin
               if (core_q[i] == CS_RUNNING) begin
                  if (halt[i]) begin
                     core_d[i] = CS_HALTED;
                  end else if (exception[i]) begin
                     core_d[i]        = CS_FAULT;
                     fault_cycle_d[i] = cycle_q;
                     pending_d[i]     = 1'b1;
                  end else if (cycle_q == CNT_W'(TIMEOUT)) begin
                     core_d[i] = CS_TIMEOUT;
                  end
               end
            end
         end

         // Full FIFO back-pressures the arbiter; pending bits simply wait
         push = sel_vld && (!fifo_full || pop);
         if (push) begin
            fifo_d[wr_ptr_q] = {sel, fault_cycle_q[sel]};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            pending_d[sel]   = 1'b0;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q       <= '0;
         core_q        <= '0;
         fault_cycle_q <= '0;
         pending_q     <= '0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         fifo_q        <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         cycle_q       <= cycle_d;
         core_q        <= core_d;
         fault_cycle_q <= fault_cycle_d;
         pending_q     <= pending_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         fifo_q        <= fifo_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   assign cycle_count      = cycle_q;
   assign core_state       = core_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign log_if.log_valid = (count_q != '0);
   assign log_if.log_core  = fifo_q[rd_ptr_q][LOG_W-1:CNT_W];
   assign log_if.log_cycle = fifo_q[rd_ptr_q][CNT_W-1:0];

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed scoreboard bench for cpu_run_monitor: expected log entries are
// queued by the stimulus and checked by an independent log monitor.
module tb_cpu_run_monitor;
   localparam int unsigned NUM_CPUS  = 4;
   localparam int unsigned CNT_W     = 32;
   localparam int unsigned TIMEOUT   = 20;
   localparam int unsigned LOG_DEPTH = 2;
   localparam int unsigned CORE_W    = 2;
   localparam int unsigned ENT_W     = CORE_W + CNT_W;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [NUM_CPUS-1:0]   halt;
   logic [NUM_CPUS-1:0]   exception;
   logic [CNT_W-1:0]      cycle_count;
   logic [3*NUM_CPUS-1:0] core_state;
   logic                  done;
   logic                  pass;

   int total = 0;
   int bad   = 0;
   logic [ENT_W-1:0] exp_q[$];

   cpu_run_monitor_if #(.CORE_W(CORE_W), .CNT_W(CNT_W)) log_if ();

   cpu_run_monitor #(
      .NUM_CPUS (NUM_CPUS),
      .CNT_W    (CNT_W),
      .TIMEOUT  (TIMEOUT),
      .LOG_DEPTH(LOG_DEPTH),
      .CORE_W   (CORE_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .halt       (halt),
      .exception  (exception),
      .cycle_count(cycle_count),
      .core_state (core_state),
      .done       (done),
      .pass       (pass),
      .log_if     (log_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Log monitor: compare the FIFO head every valid cycle, retire on handshake
   always @(negedge clk) begin
      if (!rst && log_if.log_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL log_unexpected: got core=%0d cycle=%0d expected no entry",
                     log_if.log_core, log_if.log_cycle);
         end else begin
            chk("log_entry", 64'({log_if.log_core, log_if.log_cycle}), 64'(exp_q[0]));
            if (log_if.log_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; halt = '0; exception = '0; log_if.log_ready = 1'b1;
      tick(2);
      chk("rst_cycle", 64'(cycle_count), 64'd0);
      chk("rst_core_state", 64'(core_state), 64'h000);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_pass", 64'(pass), 64'd0);
      chk("rst_log_valid", 64'(log_if.log_valid), 64'd0);
      rst = 1'b0;
      tick(2);
      chk("idle_cycle", 64'(cycle_count), 64'd0);

      // All cores halt cleanly
      pulse_start();
      chk("t1_running", 64'(core_state), 64'h249);
      chk("t1_cycle0", 64'(cycle_count), 64'd0);
      tick(5);
      halt = 4'b1101; tick(); halt = '0;
      chk("t1_partial", 64'(core_state), 64'h48A);
      tick(3);
      halt = 4'b0010; tick(); halt = '0;
      chk("t1_all_halted", 64'(core_state), 64'h492);
      chk("t1_not_done_yet", 64'(done), 64'd0);
      tick();
      chk("t1_done", 64'(done), 64'd1);
      chk("t1_pass", 64'(pass), 64'd1);
      chk("t1_cycle", 64'(cycle_count), 64'd10);
      tick(3);
      chk("t1_cycle_frozen", 64'(cycle_count), 64'd10);

      // Illegal instruction on core 1; halt+exception on core 0 is a clean stop
      pulse_start();
      chk("t2_restart_done", 64'(done), 64'd0);
      tick(3);
      halt = 4'b1101; exception = 4'b0001; tick(); halt = '0; exception = '0;
      tick(3);
      exception = 4'b0010;
      exp_q.push_back({2'd1, 32'd7});
      tick(); exception = '0;
      chk("t2_states", 64'(core_state), 64'h49A);
      chk("t2_not_done", 64'(done), 64'd0);
      tick(2);
      chk("t2_done", 64'(done), 64'd1);
      chk("t2_pass", 64'(pass), 64'd0);
      chk("t2_cycle", 64'(cycle_count), 64'd9);
      chk("t2_log_drained", 64'(exp_q.size()), 64'd0);
      chk("t2_log_valid", 64'(log_if.log_valid), 64'd0);

      // Simultaneous faults under back-pressure
      log_if.log_ready = 1'b0;
      pulse_start();
      tick(4);
      exception = 4'hF;
      for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), 32'd4});
      tick(); exception = '0;
      chk("t3_all_fault", 64'(core_state), 64'h6DB);
      tick(5);
      chk("t3_held_not_done", 64'(done), 64'd0);
      chk("t3_held_valid", 64'(log_if.log_valid), 64'd1);
      chk("t3_held_queue", 64'(exp_q.size()), 64'd4);
      log_if.log_ready = 1'b1;
      tick(6);
      chk("t3_done", 64'(done), 64'd1);
      chk("t3_pass", 64'(pass), 64'd0);
      chk("t3_all_drained", 64'(exp_q.size()), 64'd0);
      chk("t3_log_valid", 64'(log_if.log_valid), 64'd0);

      // Timeout on core 0
      pulse_start();
      tick(2);
      halt = 4'b1110; tick(); halt = '0;
      tick(17);
      chk("t4_cycle20", 64'(cycle_count), 64'd20);
      chk("t4_still_running", 64'(core_state), 64'h491);
      tick();
      chk("t4_timeout", 64'(core_state), 64'h494);
      chk("t4_not_done", 64'(done), 64'd0);
      tick();
      chk("t4_done", 64'(done), 64'd1);
      chk("t4_pass", 64'(pass), 64'd0);
      chk("t4_cycle", 64'(cycle_count), 64'd21);

      // Halt exactly at the timeout cycle wins
      pulse_start();
      tick(2);
      halt = 4'b1110; tick(); halt = '0;
      tick(17);
      halt = 4'b0001; tick(); halt = '0;
      chk("t4b_halted", 64'(core_state), 64'h492);
      tick();
      chk("t4b_done", 64'(done), 64'd1);
      chk("t4b_pass", 64'(pass), 64'd1);

      // Restart with a leftover log entry, start ignored in RUN, mid-run reset
      log_if.log_ready = 1'b0;
      pulse_start();
      tick();
      halt = 4'b1101; exception = 4'b0010;
      exp_q.push_back({2'd1, 32'd1});
      tick(); halt = '0; exception = '0;
      tick(4);
      chk("t5_done", 64'(done), 64'd1);
      chk("t5_leftover_valid", 64'(log_if.log_valid), 64'd1);
      pulse_start();
      exp_q.delete();
      chk("t5_flushed", 64'(log_if.log_valid), 64'd0);
      chk("t5_cycle0", 64'(cycle_count), 64'd0);
      chk("t5_running", 64'(core_state), 64'h249);
      chk("t5_done_clr", 64'(done), 64'd0);
      tick(3);
      pulse_start();
      chk("t5_start_ignored", 64'(cycle_count), 64'd4);
      exception = 4'b0100;
      exp_q.push_back({2'd2, 32'd4});
      tick(); exception = '0;
      tick(2);
      chk("t5_pre_rst_valid", 64'(log_if.log_valid), 64'd1);
      rst = 1'b1;
      tick();
      exp_q.delete();
      rst = 1'b0;
      chk("t5_rst_cycle", 64'(cycle_count), 64'd0);
      chk("t5_rst_core_state", 64'(core_state), 64'h000);
      chk("t5_rst_done", 64'(done), 64'd0);
      chk("t5_rst_pass", 64'(pass), 64'd0);
      chk("t5_rst_log_valid", 64'(log_if.log_valid), 64'd0);
      tick(3);
      chk("t5_idle_after_rst", 64'(cycle_count), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
